// File: rtl/chip8_draw_ctrl.sv
// DXYN sequencer: fetches N sprite bytes, issues one display draw per row, ORs collisions into VF.
// Optional build macro CHIP8_VCLIP_EN: skip rows that fall below the bottom of the screen.
module chip8_draw_ctrl #(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        vx,
  input  logic [7:0]        vy,
  input  logic [3:0]        n,
  input  logic [ADDR_W-1:0] i_reg,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  output logic              disp_draw,
  output logic [5:0]        disp_x,
  output logic [4:0]        disp_y,
  output logic [3:0]        disp_row,
  output logic [7:0]        disp_sprite,
  input  logic              disp_collision,
  output logic              busy,
  output logic              done,
  output logic              vf_we,
  output logic              vf_out,
  output logic [2:0]        dbg_state
);

  typedef enum logic [2:0] {IDLE, FETCH, WAIT, DRAW, CHECK, FIN} state_e;

  state_e            state_q, state_d;
  logic [5:0]        x_q, x_d;
  logic [4:0]        y_q, y_d;
  logic [3:0]        n_q, n_d;
  logic [3:0]        row_q, row_d;
  logic [ADDR_W-1:0] i_q, i_d;
  logic              acc_q, acc_d;
  logic              vf_q, vf_d;
  logic [5:0]        dx_q, dx_d;
  logic [4:0]        dy_q, dy_d;
  logic [3:0]        drow_q, drow_d;
  logic [7:0]        dspr_q, dspr_d;

  logic [5:0] y_cur, y_nxt;
  logic       row_clipped, next_clipped;

  // Bit 5 of the sum marks a row at or beyond screen line 32.
  assign y_cur = {1'b0, y_q} + {2'b00, row_q};
  assign y_nxt = y_cur + 6'd1;

`ifdef CHIP8_VCLIP_EN
  assign row_clipped  = y_cur[5];
  assign next_clipped = y_nxt[5];
`else
  assign row_clipped  = 1'b0;
  assign next_clipped = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      n_q     <= '0;
      row_q   <= '0;
      i_q     <= '0;
      acc_q   <= 1'b0;
      vf_q    <= 1'b0;
      dx_q    <= '0;
      dy_q    <= '0;
      drow_q  <= '0;
      dspr_q  <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      n_q     <= n_d;
      row_q   <= row_d;
      i_q     <= i_d;
      acc_q   <= acc_d;
      vf_q    <= vf_d;
      dx_q    <= dx_d;
      dy_q    <= dy_d;
      drow_q  <= drow_d;
      dspr_q  <= dspr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    n_d       = n_q;
    row_d     = row_q;
    i_d       = i_q;
    acc_d     = acc_q;
    vf_d      = vf_q;
    dx_d      = dx_q;
    dy_d      = dy_q;
    drow_d    = drow_q;
    dspr_d    = dspr_q;
    mem_rd    = 1'b0;
    mem_addr  = '0;
    disp_draw = 1'b0;
    done      = 1'b0;
    vf_we     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          x_d     = vx[5:0];
          y_d     = vy[4:0];
          n_d     = n;
          i_d     = i_reg;
          row_d   = '0;
          acc_d   = 1'b0;
          vf_d    = 1'b0;
          state_d = (n == 4'd0) ? FIN : FETCH;
        end
      end
      FETCH: begin
        mem_rd   = 1'b1;
        mem_addr = i_q + ADDR_W'(row_q);
        state_d  = WAIT;
      end
      WAIT: begin
        // Display-facing registers only change here, so they hold outside DRAW.
        dspr_d  = mem_rdata;
        dx_d    = x_q;
        dy_d    = y_q;
        drow_d  = row_q;
        state_d = DRAW;
      end
      DRAW: begin
        disp_draw = 1'b1;
        state_d   = CHECK;
      end
      CHECK: begin
        if (!row_clipped) acc_d = acc_q | disp_collision;
        if (row_q == n_q - 4'd1) begin
          vf_d    = acc_d;
          state_d = FIN;
        end else begin
          row_d   = row_q + 4'd1;
          state_d = next_clipped ? CHECK : FETCH;
        end
      end
      FIN: begin
        done    = 1'b1;
        vf_we   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy        = (state_q != IDLE);
  assign vf_out      = vf_q;
  assign disp_x      = dx_q;
  assign disp_y      = dy_q;
  assign disp_row    = drow_q;
  assign disp_sprite = dspr_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_chip8_draw_ctrl.sv
// Bench for chip8_draw_ctrl: memory and display models around the DUT, reference computed per draw.
module tb_chip8_draw_ctrl;

`ifdef CHIP8_VCLIP_EN
  localparam bit CLIP = 1'b1;
`else
  localparam bit CLIP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  vx = '0, vy = '0;
  logic [3:0]  n = '0;
  logic [11:0] i_reg = '0;
  logic        mem_rd;
  logic [11:0] mem_addr;
  logic [7:0]  mem_rdata = '0;
  logic        disp_draw;
  logic [5:0]  disp_x;
  logic [4:0]  disp_y;
  logic [3:0]  disp_row;
  logic [7:0]  disp_sprite;
  logic        disp_collision = 1'b0;
  logic        busy, done, vf_we, vf_out;
  logic [2:0]  dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0]  mem [4096];
  bit          env_fb [64][32];
  bit          ref_fb [64][32];
  bit          env_coll;
  logic [11:0] exp_addr_q [$];
  logic [22:0] exp_draw_q [$];

  chip8_draw_ctrl #(.ADDR_W(12)) dut (
    .clk(clk), .reset(reset), .start(start), .vx(vx), .vy(vy), .n(n), .i_reg(i_reg),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .disp_draw(disp_draw), .disp_x(disp_x), .disp_y(disp_y), .disp_row(disp_row),
    .disp_sprite(disp_sprite), .disp_collision(disp_collision),
    .busy(busy), .done(done), .vf_we(vf_we), .vf_out(vf_out), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  // Memory read port: data one cycle after the strobe.
  always @(posedge clk) begin
    if (mem_rd) mem_rdata <= mem[mem_addr];
  end

  // Display datapath: XOR one sprite row, collision flag valid the next cycle.
  always @(posedge clk) begin
    if (disp_draw) begin
      env_coll = 1'b0;
      for (int c = 0; c < 8; c++) begin
        if (disp_sprite[7-c]) begin
          if (env_fb[(int'(disp_x) + c) % 64][(int'(disp_y) + int'(disp_row)) % 32]) env_coll = 1'b1;
          env_fb[(int'(disp_x) + c) % 64][(int'(disp_y) + int'(disp_row)) % 32] ^= 1'b1;
        end
      end
      disp_collision <= env_coll;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic clear_fbs();
    for (int a = 0; a < 64; a++)
      for (int b = 0; b < 32; b++) begin
        env_fb[a][b] = 1'b0;
        ref_fb[a][b] = 1'b0;
      end
  endtask

  // Reference: enumerate rows, apply clipping rule, XOR into a private framebuffer.
  task automatic build_ref(input logic [7:0] vx_v, input logic [7:0] vy_v, input logic [3:0] n_v,
                           input logic [11:0] i_v, output int lat, output bit vf);
    int x, y, drawn, skipped;
    logic [11:0] a;
    logic [7:0]  b;
    logic [5:0]  xs;
    logic [4:0]  ys;
    logic [3:0]  rs;
    x = int'(vx_v) % 64;
    y = int'(vy_v) % 32;
    xs = 6'(x);
    ys = 5'(y);
    drawn = 0; skipped = 0; vf = 1'b0;
    exp_addr_q.delete();
    exp_draw_q.delete();
    for (int r = 0; r < int'(n_v); r++) begin
      if (CLIP && (y + r >= 32)) skipped++;
      else begin
        drawn++;
        a = 12'((int'(i_v) + r) % 4096);
        b = mem[a];
        rs = 4'(r);
        exp_addr_q.push_back(a);
        exp_draw_q.push_back({xs, ys, rs, b});
        for (int c = 0; c < 8; c++) begin
          if (b[7-c]) begin
            if (ref_fb[(x + c) % 64][(y + r) % 32]) vf = 1'b1;
            ref_fb[(x + c) % 64][(y + r) % 32] ^= 1'b1;
          end
        end
      end
    end
    lat = (n_v == 4'd0) ? 1 : 4 * drawn + skipped + 1;
  endtask

  // Called at a negedge; start is sampled at the following posedge (edge 0).
  task automatic run_draw(input logic [7:0] vx_v, input logic [7:0] vy_v, input logic [3:0] n_v,
                          input logic [11:0] i_v, input bit ghost, input int abort_at);
    int lat, cyc;
    bit vf, got_done;
    build_ref(vx_v, vy_v, n_v, i_v, lat, vf);
    vx = vx_v; vy = vy_v; n = n_v; i_reg = i_v;
    start = 1'b1;
    cyc = 0;
    got_done = 1'b0;
    while (!got_done && cyc < 200) begin
      @(negedge clk);
      cyc++;
      start = ghost && (cyc == 2 || cyc == 5);
      if (cyc == abort_at) begin
        reset = 1'b1;
        start = 1'b0;
        #1;
        check("rst_outs", {mem_rd, mem_addr, disp_draw, disp_x, disp_y, disp_row, disp_sprite},  '0);
        check("rst_ctrl", {busy, done, vf_we, vf_out}, '0);
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 10; k++) begin
          @(negedge clk);
          check("post_rst_idle", {busy, done, vf_we, mem_rd, disp_draw}, '0);
        end
        clear_fbs();
        return;
      end
      check("busy", busy, 1'b1);
      if (mem_rd) begin
        if (exp_addr_q.size() == 0) check("extra_rd", 1, 0);
        else check("mem_addr", mem_addr, exp_addr_q.pop_front());
      end
      if (disp_draw) begin
        if (exp_draw_q.size() == 0) check("extra_draw", 1, 0);
        else check("draw_xyrs", {disp_x, disp_y, disp_row, disp_sprite}, exp_draw_q.pop_front());
      end
      if (done) begin
        got_done = 1'b1;
        check("latency", cyc, lat);
        check("vf_we", vf_we, 1'b1);
        check("vf_out", vf_out, vf);
        check("rd_left", exp_addr_q.size(), 0);
        check("draw_left", exp_draw_q.size(), 0);
        start = ghost;
      end else begin
        check("vf_we_early", vf_we, 1'b0);
      end
    end
    if (!got_done) check("done_timeout", cyc, lat);
    @(negedge clk);
    start = 1'b0;
    check("idle_after", {busy, done, vf_we, disp_draw, mem_rd}, '0);
    check("vf_hold", vf_out, vf);
  endtask

  initial begin
    for (int a = 0; a < 4096; a++) mem[a] = 8'($urandom_range(0, 255));
    mem[12'h050] = 8'hF0; mem[12'h051] = 8'h90; mem[12'h052] = 8'h90;
    mem[12'h053] = 8'h90; mem[12'h054] = 8'hF0;
    clear_fbs();
    #1;
    check("reset_outs", {mem_rd, mem_addr, disp_draw, disp_x, disp_y, disp_row, disp_sprite}, '0);
    check("reset_ctrl", {busy, done, vf_we, vf_out}, '0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    run_draw(8'd0, 8'd0, 4'd5, 12'h050, 1'b0, 0);
    run_draw(8'd0, 8'd0, 4'd5, 12'h050, 1'b0, 0);
    run_draw(8'd70, 8'd40, 4'd1, 12'h123, 1'b0, 0);
    run_draw(8'd5, 8'd5, 4'd0, 12'h200, 1'b0, 0);
    run_draw(8'd10, 8'd3, 4'd3, 12'h300, 1'b1, 0);
    run_draw(8'd12, 8'd30, 4'd4, 12'h400, 1'b0, 0);
    run_draw(8'd60, 8'd31, 4'd15, 12'h500, 1'b0, 0);
    run_draw(8'd1, 8'd2, 4'd3, 12'hFFE, 1'b0, 0);
    run_draw(8'd1, 8'd2, 4'd3, 12'hFFE, 1'b0, 6);

    for (int t = 0; t < 30; t++) begin
      run_draw(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 4'($urandom_range(0, 15)),
               12'($urandom_range(0, 4095)), 1'($urandom_range(0, 1)), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/chip8_draw_ctrl.md
# chip8_draw_ctrl

Sequencer for the CHIP-8 DXYN instruction. On a start pulse from the CPU core it fetches N sprite bytes from memory at I..I+N-1, drives the display datapath one row per draw pulse, accumulates the per-row collision flags, and returns the final VF value with a write strobe. It sits between the CPU execute stage, the main memory read port, and the chip8_display row-XOR datapath.

## Interface
Parameters:
- ADDR_W, 12, memory address width (I register width)

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high; forces IDLE and all outputs to 0
- start  in  1  one-cycle request to execute DXYN; sampled only in IDLE
- vx  in  8  Vx value (sprite x origin)
- vy  in  8  Vy value (sprite y origin)
- n  in  4  sprite height in rows
- i_reg  in  ADDR_W  sprite base address
- mem_rd  out  1  memory read strobe
- mem_addr  out  ADDR_W  memory read address
- mem_rdata  in  8  read data, valid exactly one cycle after mem_rd
- disp_draw  out  1  one-cycle draw strobe to display datapath
- disp_x  out  6  sprite x origin, vx mod 64
- disp_y  out  5  sprite y origin, vy mod 32
- disp_row  out  4  current row index
- disp_sprite  out  8  latched sprite byte for current row
- disp_collision  in  1  display collision flag, valid the cycle after disp_draw
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle completion pulse
- vf_we  out  1  one-cycle VF write strobe, coincident with done
- vf_out  out  1  collision result (1 = at least one pixel erased)

## Operation
- States: IDLE, FETCH, WAIT, DRAW, CHECK, FIN.
- IDLE: on start, latch x = vx[5:0], y = vy[4:0], n, i_reg; clear row counter and collision accumulator; go FETCH, or FIN if n == 0.
- FETCH: mem_rd = 1, mem_addr = i_latched + row (modulo 2^ADDR_W, wraps silently); go WAIT.
- WAIT: capture mem_rdata into sprite register; go DRAW.
- DRAW: disp_draw = 1 with disp_row = row, disp_sprite = captured byte; go CHECK.
- CHECK: acc |= disp_collision; if row == n-1 go FIN, else row++ and go FETCH.
- FIN: done = vf_we = 1, vf_out = acc; go IDLE.
- disp_x/disp_y/disp_row/disp_sprite hold their last values outside DRAW; only disp_draw qualifies them.
- start while busy is ignored (no queueing).
- Horizontal wrap is handled by the display datapath; this block only reduces the origin modulo 64/32.
- Row vertical handling per Configuration.

## Timing
- Reset values: mem_rd, disp_draw, busy, done, vf_we, vf_out = 0; disp_x, disp_y, disp_row, disp_sprite, mem_addr = 0; state IDLE.
- Reset asserted mid-operation: immediate return to IDLE, no done/vf_we; no pending draw completes.
- 4 cycles per row. With start sampled at edge 0, done is high in cycle 4N+1 (n ≥ 1); n == 0 gives done in cycle 1, vf_out = 0.
- busy high from cycle 1 through the done cycle inclusive; start in the done cycle is ignored, start in the following cycle is accepted.
- vf_out holds its value until the next accepted start clears it.

## Configuration
- CHIP8_VCLIP_EN defined: rows with y + row ≥ 32 are skipped. Skipped rows issue no mem_rd and no disp_draw, cost 1 cycle (CHECK only), and contribute 0 to collision. Sprite origin still wraps (vy mod 32).
- Undefined: every row is drawn; the display datapath wraps vertically.

## Test plan
- vx=0, vy=0, n=5, i_reg=0x050, memory F0 90 90 90 F0 on cleared display -> 5 draws at rows 0..4, mem_addr 0x050..0x054, done in cycle 21, vf_out=0.
- Repeat the identical draw -> display cleared, vf_out=1, vf_we pulse with done.
- vx=70, vy=40, n=1 -> disp_x=6, disp_y=8, single draw, done in cycle 5.
- n=0 -> no mem_rd, no disp_draw, done and vf_we in cycle 1, vf_out=0; start pulses during busy of a prior n=3 draw produce no extra draws.
- vy=30, n=4: CHIP8_VCLIP_EN defined -> 2 draws (rows 0,1), done in cycle 11; undefined -> 4 draws, done in cycle 17.
- i_reg=0xFFE, n=3 -> mem_addr FFE, FFF, 000; reset asserted in WAIT of row 1 -> all outputs 0 immediately, no done.
